// File: rtl/cache_refill_sched.sv
`default_nettype none
// ============================================================================
// Module   : cache_refill_sched
// Purpose  : Sequences cache line refills (demand critical-word-first with
//            early restart, prefetch from word 0) over a single word port.
// Revision : 1.0 - initial release
// ============================================================================
module cache_refill_sched #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 30
) (
    input  logic              i_hclk,
    input  logic              i_hreset,
    input  logic              i_dem_req,
    input  logic [ADDR_W-1:0] i_dem_addr,
    output logic              o_dem_gnt,
    output logic              o_dem_done,
    input  logic              i_pf_req,
    input  logic [ADDR_W-1:0] i_pf_addr,
    output logic              o_pf_gnt,
    output logic              o_pf_done,
    output logic              o_err,
    output logic              o_busy,
    output logic              o_crit_valid,
    output logic [31:0]       o_crit_data,
    output logic              o_sl_en,
    output logic [ADDR_W-1:0] o_sl_addr,
    input  logic              i_sl_ready,
    input  logic              i_sl_resp,
    input  logic [31:0]       i_sl_rdata,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata
);

    localparam int              c_wb   = $clog2(LINE_WORDS);
    localparam logic [c_wb-1:0] c_last = c_wb'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [ADDR_W-c_wb-1:0]   r_line;
    logic [c_wb-1:0]          r_idx;
    logic [c_wb-1:0]          r_cnt;
    logic                     r_kind_dem;
    logic                     r_err;
    logic [31:0]              r_data;
    logic                     w_unused_pf_word;

    // Prefetch always starts at word 0, so its word-select bits carry no information.
    assign w_unused_pf_word = ^i_pf_addr[c_wb-1:0];

    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        o_dem_gnt    = 1'b0;
        o_pf_gnt     = 1'b0;
        o_dem_done   = 1'b0;
        o_pf_done    = 1'b0;
        o_err        = 1'b0;
        o_busy       = (r_state != S_IDLE);
        o_crit_valid = 1'b0;
        o_crit_data  = '0;
        o_sl_en      = 1'b0;
        o_sl_addr    = '0;
        o_mem_we     = 1'b0;
        o_mem_addr   = '0;
        o_mem_wdata  = '0;
        case (r_state)
            S_IDLE: begin
                // Grants are combinational; hold them low while reset is applied.
                if (!i_hreset) begin
                    if (i_dem_req) begin
                        o_dem_gnt   = 1'b1;
                        w_state_nxt = S_FETCH;
                    end else if (i_pf_req) begin
                        o_pf_gnt    = 1'b1;
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                o_sl_en   = 1'b1;
                o_sl_addr = {r_line, r_idx};
                if (i_sl_ready) begin
                    w_state_nxt = i_sl_resp ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: begin
                o_mem_we    = 1'b1;
                o_mem_addr  = {r_line, r_idx};
                o_mem_wdata = r_data;
                if (r_kind_dem && (r_cnt == '0)) begin
                    o_crit_valid = 1'b1;
                    o_crit_data  = r_data;
                end
                w_state_nxt = (r_cnt == c_last) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                o_dem_done  = r_kind_dem;
                o_pf_done   = !r_kind_dem;
                o_err       = r_err;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) begin
            r_line     <= '0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_kind_dem <= 1'b0;
            r_err      <= 1'b0;
            r_data     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_dem_req) begin
                        r_line     <= i_dem_addr[ADDR_W-1:c_wb];
                        r_idx      <= i_dem_addr[c_wb-1:0];
                        r_cnt      <= '0;
                        r_kind_dem <= 1'b1;
                    end else if (i_pf_req) begin
                        r_line     <= i_pf_addr[ADDR_W-1:c_wb];
                        r_idx      <= '0;
                        r_cnt      <= '0;
                        r_kind_dem <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (i_sl_ready) begin
                        if (i_sl_resp) begin
                            r_err <= 1'b1;
                        end else begin
                            r_data <= i_sl_rdata;
                        end
                    end
                end
                S_WRITE: begin
                    // Index wraps inside the line so a demand fill covers every word once.
                    r_idx <= r_idx + 1'b1;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_DONE: begin
                    r_err <= 1'b0;
                end
                default: begin
                    r_err <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_refill_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_refill_sched
// Purpose  : Directed self-checking bench for cache_refill_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_refill_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        dem_req, pf_req;
    logic [29:0] dem_addr, pf_addr;
    logic        dem_gnt, dem_done, pf_gnt, pf_done, err, busy;
    logic        crit_valid;
    logic [31:0] crit_data;
    logic        sl_en, sl_ready, sl_resp;
    logic [29:0] sl_addr;
    logic [31:0] sl_rdata;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;

    always #5 clk = ~clk;

    cache_refill_sched #(.LINE_WORDS(4), .ADDR_W(30)) u_dut (
        .i_hclk       (clk),
        .i_hreset     (rst),
        .i_dem_req    (dem_req),
        .i_dem_addr   (dem_addr),
        .o_dem_gnt    (dem_gnt),
        .o_dem_done   (dem_done),
        .i_pf_req     (pf_req),
        .i_pf_addr    (pf_addr),
        .o_pf_gnt     (pf_gnt),
        .o_pf_done    (pf_done),
        .o_err        (err),
        .o_busy       (busy),
        .o_crit_valid (crit_valid),
        .o_crit_data  (crit_data),
        .o_sl_en      (sl_en),
        .o_sl_addr    (sl_addr),
        .i_sl_ready   (sl_ready),
        .i_sl_resp    (sl_resp),
        .i_sl_rdata   (sl_rdata),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [31:0] rd(input logic [29:0] a);
        return 32'hC0DE_0000 ^ {2'b00, a};
    endfunction

    // Slave model: answers after wait_n idle cycles, optional error on one address.
    int          wait_n  = 0;
    logic        err_en  = 1'b0;
    logic [29:0] err_addr = '0;
    int          wcnt;

    always @* begin
        sl_ready = sl_en && (wcnt == wait_n);
        sl_resp  = sl_ready && err_en && (sl_addr == err_addr);
        sl_rdata = rd(sl_addr);
    end

    always @(posedge clk or posedge rst) begin
        if (rst)                    wcnt <= 0;
        else if (sl_en && !sl_ready) wcnt <= wcnt + 1;
        else                        wcnt <= 0;
    end

    int          cyc = 0;
    int          dem_gnt_n, pf_gnt_n, dem_done_n, pf_done_n, we_cnt, crit_cnt, unstable, en_cyc;
    int          dem_gnt_cyc, pf_gnt_cyc, dem_done_cyc, pf_done_cyc;
    logic        done_err;
    logic [31:0] crit_val;
    logic        prev_en = 1'b0;
    logic [29:0] prev_addr = '0;
    logic [29:0] beat_q[$];
    logic [29:0] wa_q[$];
    logic [31:0] wd_q[$];

    always @(negedge clk) begin
        cyc++;
        if (dem_gnt)  begin dem_gnt_n++;  dem_gnt_cyc  = cyc; end
        if (pf_gnt)   begin pf_gnt_n++;   pf_gnt_cyc   = cyc; end
        if (dem_done) begin dem_done_n++; dem_done_cyc = cyc; done_err = err; end
        if (pf_done)  begin pf_done_n++;  pf_done_cyc  = cyc; done_err = err; end
        if (sl_en) en_cyc++;
        if (sl_en && sl_ready) beat_q.push_back(sl_addr);
        if (mem_we) begin
            we_cnt++;
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
        end
        if (crit_valid) begin crit_cnt++; crit_val = crit_data; end
        if (sl_en && prev_en && (sl_addr != prev_addr)) unstable++;
        prev_en   = sl_en;
        prev_addr = sl_addr;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        dem_gnt_n = 0; pf_gnt_n = 0; dem_done_n = 0; pf_done_n = 0;
        we_cnt = 0; crit_cnt = 0; unstable = 0; en_cyc = 0;
        dem_gnt_cyc = 0; pf_gnt_cyc = 0; dem_done_cyc = 0; pf_done_cyc = 0;
        done_err = 1'b0; crit_val = '0;
        beat_q.delete(); wa_q.delete(); wd_q.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int ev_count(input int which);
        case (which)
            0:       return dem_gnt_n;
            1:       return pf_gnt_n;
            2:       return dem_done_n;
            3:       return pf_done_n;
            default: return we_cnt;
        endcase
    endfunction

    task automatic wait_ev(input int which, input int target, input int budget, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            #2;
            if (ev_count(which) >= target) ok = 1'b1;
        end
        if (!ok) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_line(input string tag, input logic [29:0] start, input int off);
        logic [29:0] a;
        for (int i = 0; i < 4; i++) begin
            a = {start[29:2], 2'(start[1:0] + 2'(i))};
            check($sformatf("%s_beat%0d", tag, i), {2'b00, beat_q[off+i]}, {2'b00, a});
            check($sformatf("%s_wa%0d", tag, i),   {2'b00, wa_q[off+i]},   {2'b00, a});
            check($sformatf("%s_wd%0d", tag, i),   wd_q[off+i],            rd(a));
        end
    endtask

    task automatic demand_line(input logic [29:0] a, input string tag);
        step();
        dem_addr = a;
        dem_req  = 1'b1;
        wait_ev(0, 1, 5, {tag, "_gnt"});
        step();
        dem_req = 1'b0;
        wait_ev(2, 1, 60, {tag, "_done"});
    endtask

    initial begin
        bit found;
        rst = 1'b1; dem_req = 1'b1; pf_req = 1'b1;
        dem_addr = 30'h3; pf_addr = 30'h5;
        clear_mon();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", {30'd0, dem_gnt, pf_gnt}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ctl", {26'd0, sl_en, mem_we, crit_valid, dem_done, pf_done, err}, 32'd0);
        check("rst_addr", {2'b00, sl_addr | mem_addr}, 32'd0);
        dem_req = 1'b0; pf_req = 1'b0;
        step();
        rst = 1'b0;
        step();

        // Demand at word 2: critical word first, wrap within line
        clear_mon();
        demand_line(30'h102, "t1");
        check_line("t1", 30'h102, 0);
        check("t1_crit", crit_val, rd(30'h102));
        check("t1_critn", crit_cnt, 1);
        check("t1_lat", dem_done_cyc - dem_gnt_cyc, 9);
        check("t1_err", {31'd0, done_err}, 32'd0);
        check("t1_we", we_cnt, 4);

        // Simultaneous demand and prefetch
        clear_mon();
        step();
        dem_addr = 30'h301; pf_addr = 30'h202;
        dem_req = 1'b1; pf_req = 1'b1;
        wait_ev(0, 1, 5, "t2_dgnt");
        check("t2_pf_held", pf_gnt_n, 0);
        step();
        dem_req = 1'b0;
        wait_ev(1, 1, 30, "t2_pgnt");
        check("t2_pf_after", pf_gnt_cyc - dem_done_cyc, 1);
        step();
        pf_req = 1'b0;
        wait_ev(3, 1, 30, "t2_pdone");
        check_line("t2d", 30'h301, 0);
        check_line("t2p", 30'h200, 4);
        check("t2_critn", crit_cnt, 1);
        check("t2_plat", pf_done_cyc - pf_gnt_cyc, 9);

        // Demand arriving mid-prefetch waits for the line to finish
        clear_mon();
        step();
        pf_addr = 30'h400; pf_req = 1'b1;
        wait_ev(1, 1, 5, "t3_pgnt");
        step();
        pf_req = 1'b0;
        wait_ev(4, 1, 10, "t3_beat1");
        step();
        dem_addr = 30'h503; dem_req = 1'b1;
        wait_ev(0, 1, 30, "t3_dgnt");
        check("t3_nopreempt", dem_gnt_cyc - pf_done_cyc, 1);
        check("t3_dgnt_n", dem_gnt_n, 1);
        step();
        dem_req = 1'b0;
        wait_ev(2, 1, 30, "t3_ddone");
        check_line("t3p", 30'h400, 0);
        check_line("t3d", 30'h503, 4);

        // Slave error on the second beat aborts the line
        clear_mon();
        err_en = 1'b1; err_addr = 30'h601;
        demand_line(30'h600, "t4");
        check("t4_we", we_cnt, 1);
        check("t4_wa", {2'b00, wa_q[0]}, {2'b00, 30'h600});
        check("t4_err", {31'd0, done_err}, 32'd1);
        check("t4_lat", dem_done_cyc - dem_gnt_cyc, 4);
        check("t4_beats", beat_q.size(), 2);
        check("t4_critn", crit_cnt, 1);
        err_en = 1'b0;
        clear_mon();
        demand_line(30'h700, "t4b");
        check("t4b_err", {31'd0, done_err}, 32'd0);
        check("t4b_we", we_cnt, 4);
        check("t4b_lat", dem_done_cyc - dem_gnt_cyc, 9);

        // Wait-state slave: address held stable until ready
        clear_mon();
        wait_n = 3;
        step();
        pf_addr = 30'h803; pf_req = 1'b1;
        wait_ev(1, 1, 5, "t5_gnt");
        step();
        pf_req = 1'b0;
        wait_ev(3, 1, 60, "t5_done");
        check("t5_stable", unstable, 0);
        check("t5_we", we_cnt, 4);
        check("t5_en_cyc", en_cyc, 16);
        check("t5_lat", pf_done_cyc - pf_gnt_cyc, 21);
        check_line("t5", 30'h800, 0);
        wait_n = 0;

        // Asynchronous reset in WRITE abandons the line
        clear_mon();
        step();
        dem_addr = 30'h900; dem_req = 1'b1;
        wait_ev(0, 1, 5, "t6_gnt");
        step();
        dem_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (mem_we) found = 1'b1;
        end
        check("t6_in_write", {31'd0, found}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("t6_ctl", {27'd0, mem_we, busy, sl_en, crit_valid, dem_done}, 32'd0);
        check("t6_maddr", {2'b00, mem_addr}, 32'd0);
        check("t6_wdata", mem_wdata, 32'd0);
        step();
        rst = 1'b0;
        repeat (3) step();
        check("t6_nodone", dem_done_n + pf_done_n, 0);
        check("t6_idle", {31'd0, busy}, 32'd0);
        clear_mon();
        demand_line(30'hA01, "t6b");
        check_line("t6b", 30'hA01, 0);
        check("t6b_lat", dem_done_cyc - dem_gnt_cyc, 9);
        check("t6b_err", {31'd0, done_err}, 32'd0);
        check("t6b_crit", crit_val, rd(30'hA01));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
